// File: rtl/avg8_post.sv
// avg8_post
//   Post-processing stage for the 8-input pipelined adder. The adder has no valid
//   signal of its own. This block rebuilds sample validity with a delay line that
//   matches the adder latency. The block then divides the sum by 2^SHIFT with
//   round-half-up and saturates the result to OUT_W signed bits. Results are queued
//   in a small show-ahead FIFO that has a valid/ready output. The adder cannot be
//   stalled, so a result that arrives while the FIFO is full is dropped and a sticky
//   flag is raised.
//
// Ports
//   clk         rising-edge clock, shared with the adder
//   rst_n       asynchronous active-low reset
//   in_valid    high in the cycle the adder inputs are presented
//   sum         adder sum, 15-bit signed, valid LATENCY cycles after in_valid
//   clr_ovf     synchronous clear of ovf_sticky
//   out_ready   consumer accepts the FIFO head
//   out_valid   FIFO head valid
//   out_data    rounded/saturated average (holds its last value while out_valid=0)
//   fifo_level  occupied FIFO entries
//   ovf_sticky  at least one result was dropped because the FIFO was full
//   sat_flag    head word was saturated
module avg8_post #(
    parameter int LATENCY    = 5,
    parameter int SHIFT      = 3,
    parameter int OUT_W      = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    input  logic [14:0]                        sum,
    input  logic                               clr_ovf,
    input  logic                               out_ready,
    output logic                               out_valid,
    output logic [OUT_W-1:0]                   out_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               ovf_sticky,
    output logic                               sat_flag
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH+1);

    // 17 bits of headroom: the rounding addend cannot overflow for any legal SHIFT.
    localparam logic signed [16:0] RND   = 17'((1 << SHIFT) >> 1);
    localparam logic signed [16:0] MAX_V = 17'((1 << (OUT_W-1)) - 1);
    localparam logic signed [16:0] MIN_V = 17'(-(1 << (OUT_W-1)));

    // ---------------- validity delay line ----------------
    logic [LATENCY-1:0] vld_q, vld_d;
    logic               sum_valid;

    always_comb begin
        vld_d    = vld_q;
        vld_d[0] = in_valid;
        for (int k = 1; k < LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
        end
    end

    assign sum_valid = vld_q[LATENCY-1];

    // ---------------- stage R: round, shift, saturate ----------------
    logic signed [16:0] sum_ext;
    logic signed [16:0] shifted;
    logic [OUT_W-1:0]   r_q, r_d;
    logic               rsat_q, rsat_d;
    logic               res_vld_q, res_vld_d;

    always_comb begin
        sum_ext   = {{2{sum[14]}}, sum};
        shifted   = (sum_ext + RND) >>> SHIFT;
        r_d       = r_q;
        rsat_d    = rsat_q;
        res_vld_d = sum_valid;
        // Only load while the sum is tagged valid, so stale or unknown adder
        // contents never reach the result register.
        if (sum_valid) begin
            if (shifted > MAX_V) begin
                r_d    = MAX_V[OUT_W-1:0];
                rsat_d = 1'b1;
            end else if (shifted < MIN_V) begin
                r_d    = MIN_V[OUT_W-1:0];
                rsat_d = 1'b1;
            end else begin
                r_d    = shifted[OUT_W-1:0];
                rsat_d = 1'b0;
            end
        end
    end

    // ---------------- output FIFO ----------------
    logic [OUT_W-1:0]      mem_q [FIFO_DEPTH];
    logic [OUT_W-1:0]      mem_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] smem_q, smem_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic                  out_valid_q, out_valid_d;
    logic [OUT_W-1:0]      out_data_q, out_data_d;
    logic                  sat_q, sat_d;
    logic                  pop, full, do_push, drop;

    always_comb begin
        mem_d       = mem_q;
        smem_d      = smem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ovf_d       = ovf_q;
        out_data_d  = out_data_q;
        sat_d       = sat_q;

        pop     = out_valid_q & out_ready;
        full    = (level_q == LVL_W'(FIFO_DEPTH));
        // When the FIFO is full, a pop on the same edge makes room for the push.
        do_push = res_vld_q & (~full | pop);
        drop    = res_vld_q & full & ~pop;

        if (do_push) begin
            mem_d[wr_ptr_q]  = r_q;
            smem_d[wr_ptr_q] = rsat_q;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        level_d = level_q + LVL_W'(do_push) - LVL_W'(pop);

        // A drop on the same edge as the clear wins.
        if (clr_ovf) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;

        // The head is registered from the post-update FIFO state. A word pushed
        // into an empty FIFO therefore appears one cycle later, and the last
        // value is held while the FIFO is empty.
        out_valid_d = (level_d != '0);
        if (out_valid_d) begin
            out_data_d = mem_d[rd_ptr_d];
            sat_d      = smem_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            r_q         <= '0;
            rsat_q      <= 1'b0;
            res_vld_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            smem_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            r_q         <= r_d;
            rsat_q      <= rsat_d;
            res_vld_q   <= res_vld_d;
            mem_q       <= mem_d;
            smem_q      <= smem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sat_q       <= sat_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign fifo_level = level_q;
    assign ovf_sticky = ovf_q;
    assign sat_flag   = sat_q;

endmodule

// File: tb/tb_avg8_post.sv
module tb_avg8_post;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               clr_ovf = 1'b0;
    logic               out_ready = 1'b0;
    logic signed [14:0] a_sum = '0;
    logic signed [14:0] s_pipe [5];
    logic [14:0]        sum;

    logic               out_valid, ovf_sticky, sat_flag;
    logic [11:0]        out_data;
    logic [2:0]         fifo_level;

    logic               o2_valid, o2_ovf, o2_sat;
    logic [11:0]        o2_data;
    logic [2:0]         o2_level;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Adder model: five register stages, no reset.
    always @(posedge clk) begin
        s_pipe[0] <= a_sum;
        for (int k = 1; k < 5; k++) s_pipe[k] <= s_pipe[k-1];
    end
    assign sum = s_pipe[4];

    avg8_post dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sum(sum),
        .clr_ovf(clr_ovf), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .fifo_level(fifo_level),
        .ovf_sticky(ovf_sticky), .sat_flag(sat_flag)
    );

    avg8_post #(.SHIFT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sum(sum),
        .clr_ovf(clr_ovf), .out_ready(out_ready), .out_valid(o2_valid),
        .out_data(o2_data), .fifo_level(o2_level),
        .ovf_sticky(o2_ovf), .sat_flag(o2_sat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic signed [14:0] v);
        in_valid = 1'b1;
        a_sum    = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, out_valid, 1);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // ---- reset state ----
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", $signed(out_data), 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", ovf_sticky, 0);
        chk("rst_sat", sat_flag, 0);
        rst_n = 1'b1;

        // ---- 1: single sample, latency 7 ----
        out_ready = 1'b1;
        send(15'sd800);
        for (int k = 1; k <= 9; k++) begin
            chk($sformatf("t1_valid_t+%0d", k), out_valid, (k == 7) ? 1 : 0);
            if (k == 7) begin
                chk("t1_data", $signed(out_data), 100);
                chk("t1_sat", sat_flag, 0);
            end
            tick();
        end

        // ---- 2: rounding, back-to-back ----
        send(15'sd12);
        send(-15'sd12);
        send(-15'sd13);
        send(15'sd11);
        wait_valid("t2_wait");
        chk("t2_r0", $signed(out_data), 2);
        tick();
        chk("t2_v1", out_valid, 1);
        chk("t2_r1", $signed(out_data), -1);
        tick();
        chk("t2_v2", out_valid, 1);
        chk("t2_r2", $signed(out_data), -2);
        tick();
        chk("t2_v3", out_valid, 1);
        chk("t2_r3", $signed(out_data), 1);
        tick();
        chk("t2_empty", out_valid, 0);

        // ---- 3: extremes and saturation (dut SHIFT=3, dut2 SHIFT=2) ----
        do_reset();
        out_ready = 1'b1;
        send(15'sd16376);
        send(-15'sd16384);
        send(15'sd16383);
        wait_valid("t3_wait");
        chk("t3_max", $signed(out_data), 2047);
        chk("t3_max_sat", sat_flag, 0);
        chk("t3_s2_valid", o2_valid, 1);
        chk("t3_s2_max", $signed(o2_data), 2047);
        chk("t3_s2_max_sat", o2_sat, 1);
        tick();
        chk("t3_min", $signed(out_data), -2048);
        chk("t3_min_sat", sat_flag, 0);
        chk("t3_s2_min", $signed(o2_data), -2048);
        chk("t3_s2_min_sat", o2_sat, 1);
        tick();
        chk("t3_top", $signed(out_data), 2047);
        chk("t3_top_sat", sat_flag, 1);
        chk("t3_s2_top", $signed(o2_data), 2047);
        tick();

        // ---- 4: overflow and drain ----
        do_reset();
        out_ready = 1'b0;
        for (int n = 1; n <= 6; n++) send(15'(8 * n));
        repeat (8) tick();
        chk("t4_level", fifo_level, 4);
        chk("t4_ovf", ovf_sticky, 1);
        chk("t4_valid", out_valid, 1);
        out_ready = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            chk($sformatf("t4_v%0d", e), out_valid, 1);
            chk($sformatf("t4_d%0d", e), $signed(out_data), e);
            tick();
        end
        chk("t4_drained", out_valid, 0);
        chk("t4_level0", fifo_level, 0);
        chk("t4_ovf_held", ovf_sticky, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t4_ovf_clr", ovf_sticky, 0);

        // ---- 5: full FIFO with simultaneous push/pop ----
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            a_sum    = 15'(8 * (i + 1));
            if (i >= 10) begin
                out_ready = 1'b1;
                chk($sformatf("t5_level_%0d", i), fifo_level, 4);
                chk($sformatf("t5_valid_%0d", i), out_valid, 1);
                chk($sformatf("t5_data_%0d", i), $signed(out_data), i - 9);
                chk($sformatf("t5_ovf_%0d", i), ovf_sticky, 0);
            end
            tick();
        end
        in_valid = 1'b0;
        repeat (12) tick();
        chk("t5_empty", out_valid, 0);
        chk("t5_hold", $signed(out_data), 20);

        // ---- 6: reset with samples in flight ----
        send(15'sd40);
        send(15'sd48);
        send(15'sd56);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_data", $signed(out_data), 0);
        chk("t6_level", fifo_level, 0);
        chk("t6_ovf", ovf_sticky, 0);
        chk("t6_sat", sat_flag, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("t6_noval_%0d", k), out_valid, 0);
            chk($sformatf("t6_nolvl_%0d", k), fifo_level, 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
